// File: rtl/wb_master_pkg.sv
// Shared types and defaults for the Wishbone classic initiator.
// Consumed by wb_master_ctrl and wb_timeout_cnt.
package wb_master_pkg;

  localparam int unsigned WbAdrWidthDef    = 32;
  localparam int unsigned WbDatWidthDef    = 32;
  localparam int unsigned TimeoutCyclesDef = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } wb_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts cycles without ack, flags the last allowed cycle.
// Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned      CntW    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  // Saturates at the terminal count so the flag cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LastCnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == LastCnt);

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, result on a response port.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter int unsigned wb_adr_width   = WbAdrWidthDef,
  parameter int unsigned wb_dat_width   = WbDatWidthDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [wb_adr_width-1:0]   cmd_adr,
  input  logic [wb_dat_width-1:0]   cmd_dat,
  input  logic [wb_dat_width/8-1:0] cmd_sel,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [wb_dat_width-1:0]   rsp_dat,
  output logic                      rsp_err,
  output logic [wb_adr_width-1:0]   wb_adr_o,
  output logic [wb_dat_width-1:0]   wb_dat_o,
  output logic [wb_dat_width/8-1:0] wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic [wb_dat_width-1:0]   wb_dat_i,
  input  logic                      wb_ack_i
);

  wb_state_e                 r_state, w_state_next;
  logic [wb_adr_width-1:0]   r_wb_adr;
  logic [wb_dat_width-1:0]   r_wb_dat;
  logic [wb_dat_width/8-1:0] r_wb_sel;
  logic                      r_wb_we;
  logic                      r_wb_cyc;
  logic                      r_rsp_valid;
  logic                      r_rsp_err;
  logic [wb_dat_width-1:0]   r_rsp_dat;

  logic w_accept;
  logic w_in_bus;
  logic w_timeout;
  logic w_bus_done;

  assign cmd_ready  = (r_state == StIdle);
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_in_bus   = (r_state == StBus);
  assign w_bus_done = w_in_bus & (wb_ack_i | w_timeout);

`ifdef WB_MASTER_TIMEOUT_EN
  logic w_tc;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_accept),
    .i_en (w_in_bus & ~wb_ack_i),
    .o_tc (w_tc)
  );

  assign w_timeout = w_tc;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)   w_state_next = StBus;
      StBus:   if (w_bus_done) w_state_next = StResp;
      StResp:  if (rsp_ready)  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // An ack on the terminal-count cycle wins, so the error flag is simply "no ack".
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_adr    <= '0;
      r_wb_dat    <= '0;
      r_wb_sel    <= '0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_wb_adr <= cmd_adr;
            r_wb_dat <= cmd_dat;
            r_wb_sel <= cmd_sel;
            r_wb_we  <= cmd_we;
            r_wb_cyc <= 1'b1;
          end
        end
        StBus: begin
          if (w_bus_done) begin
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ~wb_ack_i;
            r_rsp_dat   <= (wb_ack_i && !r_wb_we) ? wb_dat_i : '0;
          end
        end
        StResp: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wb_adr_o  = r_wb_adr;
  assign wb_dat_o  = r_wb_dat;
  assign wb_sel_o  = r_wb_sel;
  assign wb_we_o   = r_wb_we;
  assign wb_cyc_o  = r_wb_cyc;
  assign wb_stb_o  = r_wb_cyc;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl with a GPIO-style slave and a register-map reference model.
module tb_wb_master_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_master_ctrl #(
    .wb_adr_width  (AW),
    .wb_dat_width  (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  // GPIO slave: 0 = in (pins), 1 = out, 2 = dir, 3 = en; acks after ack_delay cycles of cyc.
  logic [31:0] s_regs [4];
  logic [31:0] gpio_in;
  logic        ack_en, stray_ack;
  int          ack_delay;
  int          s_cnt;

  assign wb_ack_i = (wb_cyc_o & wb_stb_o & ack_en & (s_cnt == ack_delay)) | stray_ack;
  assign wb_dat_i = (wb_adr_o[3:2] == 2'd0) ? gpio_in : s_regs[wb_adr_o[3:2]];

  always @(posedge clk) begin
    if (!rst) begin
      s_cnt <= 0;
      for (int i = 0; i < 4; i++) s_regs[i] <= '0;
    end else begin
      s_cnt <= wb_cyc_o ? s_cnt + 1 : 0;
      if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o && wb_adr_o[3:2] != 2'd0) begin
        for (int b = 0; b < 4; b++)
          if (wb_sel_o[b]) s_regs[wb_adr_o[3:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
    end
  end

  // Reference model: expected register contents after the commands issued so far.
  logic [31:0] ref_regs [4];

  task automatic ref_clear();
    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
  endtask

  task automatic ref_write(input logic [1:0] idx, input logic [31:0] dat, input logic [3:0] sel);
    if (idx != 2'd0)
      for (int b = 0; b < 4; b++) if (sel[b]) ref_regs[idx][8*b +: 8] = dat[8*b +: 8];
  endtask

  function automatic logic [31:0] ref_read(input logic [1:0] idx);
    return (idx == 2'd0) ? gpio_in : ref_regs[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command: issue, track BUS cycles, hold the response for `hold` cycles, then consume.
  task automatic xact(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                      input logic [3:0] sel, input int hold, input int limit,
                      output logic [31:0] rdat, output logic err, output int nbus);
    logic [31:0] adr;
    adr = ($urandom & 32'hFFFF_FFF0) | {28'd0, idx, 2'b00};
    nbus = 0;
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge clk); #1;
    // Garbage stays presented outside IDLE; it must be ignored.
    cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    @(negedge clk);
    check("cyc_after_accept", {31'd0, wb_cyc_o}, 1);
    check("wb_dat_o", wb_dat_o, dat);
    check("wb_sel_o", {28'd0, wb_sel_o}, {28'd0, sel});
    check("wb_we_o", {31'd0, wb_we_o}, {31'd0, we});
    while (!rsp_valid && nbus < limit) begin
      nbus++;
      check("bus_adr_hold", wb_adr_o, adr);
      check("stb_eq_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
      check("cmd_ready_busy", {31'd0, cmd_ready}, 0);
      @(negedge clk);
    end
    if (!rsp_valid) begin
      cmd_valid = 1'b0;
      rdat = 'x;
      err  = 1'bx;
      return;
    end
    check("cyc_low_after_ack", {31'd0, wb_cyc_o}, 0);
    rdat = rsp_dat;
    err  = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_valid_hold", {31'd0, rsp_valid}, 1);
      check("rsp_dat_hold", rsp_dat, rdat);
      check("rsp_err_hold", {31'd0, rsp_err}, {31'd0, err});
      check("cmd_ready_resp", {31'd0, cmd_ready}, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_consumed", {31'd0, rsp_valid}, 0);
    check("cmd_ready_after", {31'd0, cmd_ready}, 1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdat, edat;
    logic        err, we;
    logic [1:0]  idx;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          nbus, dly, hold, acc0, acc1, nacc;

    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack_en = 1'b1; ack_delay = 0; stray_ack = 1'b0; gpio_in = '0;
    ref_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", {31'd0, wb_cyc_o}, 0);
    check("rst_stb", {31'd0, wb_stb_o}, 0);
    check("rst_we", {31'd0, wb_we_o}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_err", {31'd0, rsp_err}, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sel", {28'd0, wb_sel_o}, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    rst = 1'b1;

    // Write dir = 0xFF through a zero-wait slave.
    xact(1'b1, 2'd2, 32'hFF, 4'hF, 0, 40, rdat, err, nbus);
    ref_write(2'd2, 32'hFF, 4'hF);
    check("wr_err", {31'd0, err}, 0);
    check("wr_rsp_dat", rdat, 0);
    check("wr_nbus", nbus, 1);
    check("slave_dir", s_regs[2], 32'hFF);

    // Pin read.
    gpio_in = 32'hA5;
    xact(1'b0, 2'd0, 32'h0, 4'hF, 0, 40, rdat, err, nbus);
    check("rd_pins", rdat, 32'h0000_00A5);
    check("rd_pins_nbus", nbus, 1);

    // Back-pressured response.
    xact(1'b0, 2'd2, 32'h0, 4'hF, 5, 40, rdat, err, nbus);
    check("rd_dir_held", rdat, 32'hFF);

    // Stray ack in IDLE must not start a response.
    @(negedge clk); stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_rsp_valid", {31'd0, rsp_valid}, 0);
    check("stray_cyc", {31'd0, wb_cyc_o}, 0);
    stray_ack = 1'b0;

    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom); idx = 2'($urandom); dat = $urandom; sel = 4'($urandom);
      dly = $urandom_range(0, 6); hold = $urandom_range(0, 3); gpio_in = $urandom;
      ack_delay = dly;
      edat = we ? 32'd0 : ref_read(idx);
      xact(we, idx, dat, sel, hold, 40, rdat, err, nbus);
      if (we) ref_write(idx, dat, sel);
      check("rnd_rsp_dat", rdat, edat);
      check("rnd_err", {31'd0, err}, 0);
      check("rnd_nbus", nbus, dly + 1);
    end

    // Ack on the 16th BUS cycle: normal completion in either build.
    ack_delay = TO - 1;
    xact(1'b0, 2'd3, 32'h0, 4'hF, 0, 40, rdat, err, nbus);
    check("late_ack_dat", rdat, ref_read(2'd3));
    check("late_ack_err", {31'd0, err}, 0);
    check("late_ack_nbus", nbus, TO);

    // Slave never acks.
    ack_en = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    xact(1'b0, 2'd1, 32'h0, 4'hF, 0, 40, rdat, err, nbus);
    check("to_nbus", nbus, TO);
    check("to_err", {31'd0, err}, 1);
    check("to_dat", rdat, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h4; cmd_dat = 32'h1; cmd_sel = 4'hF;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
`else
    xact(1'b0, 2'd1, 32'h0, 4'hF, 0, 120, rdat, err, nbus);
    check("noto_nbus", nbus, 120);
    check("noto_rsp_valid", {31'd0, rsp_valid}, 0);
`endif
    check("cyc_before_rst", {31'd0, wb_cyc_o}, 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cyc", {31'd0, wb_cyc_o}, 0);
    check("midrst_stb", {31'd0, wb_stb_o}, 0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 0);
    rst = 1'b1;
    ref_clear();
    ack_en = 1'b1; ack_delay = 0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 1);
    check("post_rst_rsp_valid", {31'd0, rsp_valid}, 0);

    xact(1'b0, 2'd2, 32'h0, 4'hF, 0, 40, rdat, err, nbus);
    check("post_rst_dir", rdat, ref_read(2'd2));

    // Back-to-back commands with zero-wait slave and rsp_ready high.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_sel = 4'hF; rsp_ready = 1'b1;
    acc0 = -1; acc1 = -1; nacc = 0;
    for (int c = 0; c < 8; c++) begin
      if (cmd_ready) begin
        if (nacc == 0) acc0 = c;
        else if (nacc == 1) acc1 = c;
        nacc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("spacing", acc1 - acc0, 3);
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    check("drain_ready", {31'd0, cmd_ready}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
